ife_exec_sequencer: RTL
=======================

Name: ife_exec_sequencer

Overview:
Per-block execution controller for the Instruction Flow Expander. It accepts one instruction block at a time from the block queue and waits for all parallel cores to go idle. It then fires the parallel dispatch and supervises the commit result with a timeout. On commit failure, timeout, or core starvation it hands the block to the serial fallback path through a req/ack/done handshake. It sits between the block queue, the dispatch unit, the commit unit and the bypass path, and replaces their current free-running, always-ready coupling.

Parameters:
BLOCK_ID_WIDTH, 8, width of the block identifier
NUM_CORES, 2, number of parallel cores gated by the sequencer
EXEC_TIMEOUT, 64, max cycles in EXEC waiting for commit_valid (>=1)
CORE_WAIT_LIMIT, 16, max cycles in WAIT_CORES before forcing serial fallback (>=1)
CNT_WIDTH, 8, width of the shared down-counter (must hold max(EXEC_TIMEOUT, CORE_WAIT_LIMIT))

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
blk_valid  in  1  upstream block available
blk_id  in  BLOCK_ID_WIDTH  upstream block id
blk_ready  out  1  sequencer can accept a block
core_busy  in  NUM_CORES  per-core busy status
dispatch_valid  out  NUM_CORES  one-cycle parallel dispatch strobe
dispatch_block_id  out  BLOCK_ID_WIDTH  id of the block in flight
commit_valid  in  1  commit unit result valid
commit_ok  in  1  parallel results consistent
commit_fail  in  1  parallel results inconsistent
serial_req  out  1  request serial re-execution of dispatch_block_id
serial_ack  in  1  serial path accepted request
serial_done  in  1  serial path finished block
block_done  out  1  one-cycle pulse, block retired
done_serial  out  1  qualifies block_done: 1 = retired via serial path
state_o  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, dispatch_block_id=0, dispatch_valid=0, serial_req=0, block_done=0, done_serial=0.
- blk_ready is combinational: 1 iff state==IDLE. Its value after reset is therefore 1.
- All other outputs are registered.
- State encodings: IDLE=0, WAIT_CORES=1, EXEC=2, SERIAL_REQ=3, SERIAL_WAIT=4. Unused encodings return to IDLE on the next cycle.
- IDLE:
  - On blk_valid && blk_ready, latch blk_id into dispatch_block_id.
  - Load counter=CORE_WAIT_LIMIT-1 and go to WAIT_CORES.
- WAIT_CORES:
  - If core_busy=='0: next cycle dispatch_valid={NUM_CORES{1}} for exactly one cycle, counter=EXEC_TIMEOUT-1, go to EXEC.
  - Else if counter==0: go to SERIAL_REQ, with no parallel dispatch.
  - Else decrement counter.
- EXEC:
  - commit_valid && commit_ok && !commit_fail: go to IDLE with block_done=1, done_serial=0 next cycle.
  - commit_valid with commit_fail=1 (including ok and fail both high): go to SERIAL_REQ.
  - No commit_valid and counter==0: timeout, go to SERIAL_REQ.
  - commit_valid in the same cycle the counter reaches 0: the commit result wins.
  - commit_valid with ok=0 and fail=0 is treated as fail.
- SERIAL_REQ:
  - serial_req=1 is held while in this state, and dispatch_block_id stays stable.
  - On serial_ack go to SERIAL_WAIT; serial_req drops the cycle after ack.
- SERIAL_WAIT:
  - On serial_done go to IDLE with block_done=1, done_serial=1 next cycle.
  - serial_done seen in SERIAL_REQ together with serial_ack is honoured: go directly to IDLE with the serial done pulse.
- commit_valid, serial_ack and serial_done outside their consuming states are ignored.
- Counter never underflows; it saturates at 0.
- Latency: with cores idle, block accept to dispatch_valid takes 2 cycles.
- Reset mid-operation aborts the block silently: no block_done, and serial_req and dispatch_valid clear immediately.

Optional Feature:
IFE_SEQ_STATS_EN: when defined, adds three 16-bit outputs, saturating at 16'hFFFF and cleared on reset:
- stat_parallel_ok: blocks retired with done_serial=0.
- stat_fallback: blocks retired with done_serial=1.
- stat_timeout: EXEC timeouts plus WAIT_CORES starvations.
When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then blk_valid=1, blk_id=8'h2A, core_busy=2'b00 -> blk_ready=0 next cycle; dispatch_valid=2'b11 for one cycle 2 cycles after accept; dispatch_block_id=8'h2A; commit_valid+ok 5 cycles later -> block_done=1, done_serial=0; back in IDLE.
- core_busy=2'b01 held, CORE_WAIT_LIMIT=16 -> no dispatch_valid; serial_req=1 after 16 WAIT_CORES cycles with id intact; serial_ack then serial_done 3 cycles later -> block_done=1, done_serial=1.
- Dispatch, then commit_valid with commit_fail=1 -> serial_req asserted next cycle and held until serial_ack, even if ack is delayed 10 cycles.
- Dispatch with no commit, EXEC_TIMEOUT=64 -> serial_req rises exactly 64 cycles after entering EXEC; variant: commit_valid+ok on the expiry cycle -> parallel retire, no serial_req.
- rst=0 asserted asynchronously mid-EXEC and mid-SERIAL_REQ -> all outputs 0 immediately, blk_ready=1 after release, no block_done.
- With IFE_SEQ_STATS_EN: 3 parallel successes, 1 fail, 1 timeout -> stat_parallel_ok=3, stat_fallback=2, stat_timeout=1.

Source files
------------

// File: rtl/ife_exec_sequencer.sv
// Per-block execution controller: gates dispatch on idle cores, supervises commit with a timeout,
// and falls back to the serial path. Define IFE_SEQ_STATS_EN to add saturating retire/timeout counters.
module ife_exec_sequencer #(
  parameter int BLOCK_ID_WIDTH  = 8,
  parameter int NUM_CORES       = 2,
  parameter int EXEC_TIMEOUT    = 64,
  parameter int CORE_WAIT_LIMIT = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid,
  input  logic [BLOCK_ID_WIDTH-1:0] blk_id,
  output logic                      blk_ready,
  input  logic [NUM_CORES-1:0]      core_busy,
  output logic [NUM_CORES-1:0]      dispatch_valid,
  output logic [BLOCK_ID_WIDTH-1:0] dispatch_block_id,
  input  logic                      commit_valid,
  input  logic                      commit_ok,
  input  logic                      commit_fail,
  output logic                      serial_req,
  input  logic                      serial_ack,
  input  logic                      serial_done,
  output logic                      block_done,
  output logic                      done_serial,
  output logic [2:0]                state_o
`ifdef IFE_SEQ_STATS_EN
  ,
  output logic [15:0]               stat_parallel_ok,
  output logic [15:0]               stat_fallback,
  output logic [15:0]               stat_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_CORES  = 3'd1,
    S_EXEC        = 3'd2,
    S_SERIAL_REQ  = 3'd3,
    S_SERIAL_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(CORE_WAIT_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] EXEC_LOAD = CNT_WIDTH'(EXEC_TIMEOUT - 1);

  state_t                      state, state_n;
  logic [CNT_WIDTH-1:0]        cnt, cnt_n;
  logic [BLOCK_ID_WIDTH-1:0]   id_n;
  logic [NUM_CORES-1:0]        dv_n;
  logic                        sreq_n, bd_n, ds_n, timeout_ev;

  assign blk_ready = (state == S_IDLE);
  assign state_o   = state;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    id_n       = dispatch_block_id;
    dv_n       = '0;
    bd_n       = 1'b0;
    ds_n       = 1'b0;
    timeout_ev = 1'b0;
    case (state)
      S_IDLE: begin
        if (blk_valid) begin
          id_n    = blk_id;
          cnt_n   = WAIT_LOAD;
          state_n = S_WAIT_CORES;
        end
      end
      S_WAIT_CORES: begin
        if (core_busy == '0) begin
          dv_n    = '1;
          cnt_n   = EXEC_LOAD;
          state_n = S_EXEC;
        end else if (cnt == '0) begin
          timeout_ev = 1'b1;
          state_n    = S_SERIAL_REQ;
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      S_EXEC: begin
        // A commit result takes priority over a timeout expiring in the same cycle.
        if (commit_valid) begin
          if (commit_ok && !commit_fail) begin
            bd_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_SERIAL_REQ;
          end
        end else if (cnt == '0) begin
          timeout_ev = 1'b1;
          state_n    = S_SERIAL_REQ;
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      S_SERIAL_REQ: begin
        if (serial_ack) begin
          if (serial_done) begin
            bd_n    = 1'b1;
            ds_n    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_SERIAL_WAIT;
          end
        end
      end
      S_SERIAL_WAIT: begin
        if (serial_done) begin
          bd_n    = 1'b1;
          ds_n    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    sreq_n = (state_n == S_SERIAL_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      dispatch_block_id <= '0;
      dispatch_valid    <= '0;
      serial_req        <= 1'b0;
      block_done        <= 1'b0;
      done_serial       <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      dispatch_block_id <= id_n;
      dispatch_valid    <= dv_n;
      serial_req        <= sreq_n;
      block_done        <= bd_n;
      done_serial       <= ds_n;
    end
  end

`ifdef IFE_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_parallel_ok <= '0;
      stat_fallback    <= '0;
      stat_timeout     <= '0;
    end else begin
      stat_parallel_ok <= sat_inc16(stat_parallel_ok, bd_n && !ds_n);
      stat_fallback    <= sat_inc16(stat_fallback, bd_n && ds_n);
      stat_timeout     <= sat_inc16(stat_timeout, timeout_ev);
    end
  end
`endif

endmodule
